// File: rtl/ace_trs_decoder.sv
// Purpose: classify ACE AW/AR requests into a transaction type and forward them through one output register.
// Latency: one cycle from input handshake to req_valid_o; sustains one request per cycle.
// Backpressure: inputs are accepted only while the entry is empty or draining this cycle; AW/AR contention alternates via a token.
module ace_trs_decoder #(
   parameter int unsigned IdWidth   = 4,
   parameter int unsigned AddrWidth = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 aw_valid_i,
   output logic                 aw_ready_o,
   input  logic [IdWidth-1:0]   aw_id_i,
   input  logic [AddrWidth-1:0] aw_addr_i,
   input  logic [2:0]           aw_snoop_i,
   input  logic [1:0]           aw_domain_i,
   input  logic [1:0]           aw_bar_i,
   input  logic                 ar_valid_i,
   output logic                 ar_ready_o,
   input  logic [IdWidth-1:0]   ar_id_i,
   input  logic [AddrWidth-1:0] ar_addr_i,
   input  logic [3:0]           ar_snoop_i,
   input  logic [1:0]           ar_domain_i,
   input  logic [1:0]           ar_bar_i,
   output logic                 req_valid_o,
   input  logic                 req_ready_i,
   output logic [2:0]           req_trs_o,
   output logic                 req_write_o,
   output logic [IdWidth-1:0]   req_id_o,
   output logic [AddrWidth-1:0] req_addr_o,
   output logic                 req_unsupported_o,
   output logic [7:0]           err_cnt_o
);

   // Transaction type encoding (ace_trs_t); R_NO_SNP is zero so the reset value is the AR fallback.
   localparam logic [2:0] R_NO_SNP  = 3'd0;
   localparam logic [2:0] R_ONCE    = 3'd1;
   localparam logic [2:0] R_SHARED  = 3'd2;
   localparam logic [2:0] C_INVALID = 3'd3;
   localparam logic [2:0] C_UNIQUE  = 3'd4;
   localparam logic [2:0] W_NO_SNP  = 3'd5;
   localparam logic [2:0] W_BACK    = 3'd6;

   typedef struct packed {
      logic [2:0]           trs;
      logic                 write;
      logic [IdWidth-1:0]   id;
      logic [AddrWidth-1:0] addr;
      logic                 unsupported;
   } entry_t;

   entry_t     entry;
   entry_t     nextEntry;
   logic       reqValid;
   logic       tokenAw;      // 0: AR wins the next contended cycle, 1: AW wins
   logic [7:0] errCnt;

   logic       canAccept;
   logic       bothValid;
   logic       grantAw;
   logic       grantAr;
   logic       accept;
   logic [2:0] arTrs;
   logic       arUnsup;
   logic [2:0] awTrs;
   logic       awUnsup;

   // Read decode: barrier requests and unlisted snoop/domain pairs fall back to R_NO_SNP, flagged.
   always_comb begin
      arTrs   = R_NO_SNP;
      arUnsup = 1'b1;
      if (!ar_bar_i[0]) begin
         if (ar_domain_i == 2'b00 || ar_domain_i == 2'b11) begin
            if (ar_snoop_i == 4'b0000) begin
               arTrs   = R_NO_SNP;
               arUnsup = 1'b0;
            end
         end else begin
            case (ar_snoop_i)
               4'b0000: begin arTrs = R_ONCE;    arUnsup = 1'b0; end
               4'b0001: begin arTrs = R_SHARED;  arUnsup = 1'b0; end
               4'b1001: begin arTrs = C_INVALID; arUnsup = 1'b0; end
               4'b1011: begin arTrs = C_UNIQUE;  arUnsup = 1'b0; end
               default: begin arTrs = R_NO_SNP;  arUnsup = 1'b1; end
            endcase
         end
      end
   end

   // Write decode: barrier requests and unlisted snoop/domain pairs fall back to W_NO_SNP, flagged.
   always_comb begin
      awTrs   = W_NO_SNP;
      awUnsup = 1'b1;
      if (!aw_bar_i[0]) begin
         if (aw_snoop_i == 3'b000 && (aw_domain_i == 2'b00 || aw_domain_i == 2'b11)) begin
            awTrs   = W_NO_SNP;
            awUnsup = 1'b0;
         end else if (aw_snoop_i == 3'b011 && aw_domain_i != 2'b11) begin
            awTrs   = W_BACK;
            awUnsup = 1'b0;
         end
      end
   end

   // Arbitration: the token only matters when both channels are valid; nothing is granted in reset.
   always_comb begin
      canAccept  = rst_ni && (!reqValid || req_ready_i);
      bothValid  = aw_valid_i && ar_valid_i;
      grantAw    = aw_valid_i && (!ar_valid_i || tokenAw);
      grantAr    = ar_valid_i && (!aw_valid_i || !tokenAw);
      aw_ready_o = canAccept && grantAw;
      ar_ready_o = canAccept && grantAr;
      accept     = aw_ready_o || ar_ready_o;
   end

   // Next entry: fields of the granted channel with its decoded type.
   always_comb begin
      nextEntry = '0;
      if (grantAw) begin
         nextEntry.trs         = awTrs;
         nextEntry.write       = 1'b1;
         nextEntry.id          = aw_id_i;
         nextEntry.addr        = aw_addr_i;
         nextEntry.unsupported = awUnsup;
      end else begin
         nextEntry.trs         = arTrs;
         nextEntry.write       = 1'b0;
         nextEntry.id          = ar_id_i;
         nextEntry.addr        = ar_addr_i;
         nextEntry.unsupported = arUnsup;
      end
   end

   // Output entry, arbitration token and saturating error counter.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         reqValid <= 1'b0;
         entry    <= '0;
         tokenAw  <= 1'b0;
         errCnt   <= 8'd0;
      end else begin
         if (accept) begin
            reqValid <= 1'b1;
            entry    <= nextEntry;
            if (bothValid) begin
               tokenAw <= ~tokenAw;
            end
            if (nextEntry.unsupported && errCnt != 8'hFF) begin
               errCnt <= errCnt + 8'd1;
            end
         end else if (req_ready_i) begin
            reqValid <= 1'b0;
         end
      end
   end

   assign req_valid_o       = reqValid;
   assign req_trs_o         = entry.trs;
   assign req_write_o       = entry.write;
   assign req_id_o          = entry.id;
   assign req_addr_o        = entry.addr;
   assign req_unsupported_o = entry.unsupported;
   assign err_cnt_o         = errCnt;

endmodule

// File: tb/tb_ace_trs_decoder.sv
// Purpose: directed table-driven checks of decode, arbitration, backpressure and reset for ace_trs_decoder.
// Latency: each vector is driven after a rising edge and its entry is sampled 1 time unit after the next edge.
// Backpressure: hand-written sequences hold req_ready_i low to exercise stalls and mid-operation reset.
module tb_ace_trs_decoder;

   localparam logic [2:0] R_NO_SNP  = 3'd0;
   localparam logic [2:0] R_ONCE    = 3'd1;
   localparam logic [2:0] R_SHARED  = 3'd2;
   localparam logic [2:0] C_INVALID = 3'd3;
   localparam logic [2:0] C_UNIQUE  = 3'd4;
   localparam logic [2:0] W_NO_SNP  = 3'd5;
   localparam logic [2:0] W_BACK    = 3'd6;

   logic        clk = 1'b0;
   logic        rstN;
   logic        awValid, awReady, arValid, arReady;
   logic [3:0]  awId, arId;
   logic [63:0] awAddr, arAddr;
   logic [2:0]  awSnoop;
   logic [3:0]  arSnoop;
   logic [1:0]  awDomain, arDomain, awBar, arBar;
   logic        reqValid, reqReady, reqWrite, reqUnsup;
   logic [2:0]  reqTrs;
   logic [3:0]  reqId;
   logic [63:0] reqAddr;
   logic [7:0]  errCnt;

   int total = 0;
   int bad   = 0;
   int expErr = 0;

   always #5 clk = ~clk;

   ace_trs_decoder #(.IdWidth(4), .AddrWidth(64)) dut (
      .clk_i(clk), .rst_ni(rstN),
      .aw_valid_i(awValid), .aw_ready_o(awReady), .aw_id_i(awId), .aw_addr_i(awAddr),
      .aw_snoop_i(awSnoop), .aw_domain_i(awDomain), .aw_bar_i(awBar),
      .ar_valid_i(arValid), .ar_ready_o(arReady), .ar_id_i(arId), .ar_addr_i(arAddr),
      .ar_snoop_i(arSnoop), .ar_domain_i(arDomain), .ar_bar_i(arBar),
      .req_valid_o(reqValid), .req_ready_i(reqReady), .req_trs_o(reqTrs),
      .req_write_o(reqWrite), .req_id_o(reqId), .req_addr_o(reqAddr),
      .req_unsupported_o(reqUnsup), .err_cnt_o(errCnt)
   );

   typedef struct {
      bit          isAw;
      logic [3:0]  id;
      logic [63:0] addr;
      logic [3:0]  snoop;
      logic [1:0]  domain;
      logic [1:0]  bar;
      logic [2:0]  expTrs;
      bit          expUnsup;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      awValid = 0; arValid = 0;
      awId = 0; arId = 0; awAddr = 0; arAddr = 0;
      awSnoop = 0; arSnoop = 0; awDomain = 0; arDomain = 0; awBar = 0; arBar = 0;
   endtask

   task automatic bumpErr();
      if (expErr < 255) expErr++;
   endtask

   initial begin
      // isAw, id, addr, snoop, domain, bar, expected type, expected unsupported
      vecs[0]  = '{0, 4'd3, 64'h1000, 4'b0001, 2'b01, 2'b00, R_SHARED,  0};
      vecs[1]  = '{0, 4'd1, 64'h1040, 4'b0000, 2'b00, 2'b00, R_NO_SNP,  0};
      vecs[2]  = '{0, 4'd2, 64'h1080, 4'b0000, 2'b11, 2'b00, R_NO_SNP,  0};
      vecs[3]  = '{0, 4'd4, 64'h10c0, 4'b0000, 2'b10, 2'b00, R_ONCE,    0};
      vecs[4]  = '{0, 4'd5, 64'h1100, 4'b1001, 2'b01, 2'b00, C_INVALID, 0};
      vecs[5]  = '{0, 4'd6, 64'h1140, 4'b1011, 2'b10, 2'b00, C_UNIQUE,  0};
      vecs[6]  = '{0, 4'd7, 64'h1180, 4'b0001, 2'b00, 2'b00, R_NO_SNP,  1};
      vecs[7]  = '{0, 4'd8, 64'h11c0, 4'b0000, 2'b01, 2'b01, R_NO_SNP,  1};
      vecs[8]  = '{0, 4'd9, 64'h1200, 4'b0111, 2'b01, 2'b00, R_NO_SNP,  1};
      vecs[9]  = '{0, 4'd10, 64'h1240, 4'b0000, 2'b01, 2'b10, R_ONCE,   0};
      vecs[10] = '{1, 4'd11, 64'hdead_beef_0000_0000, 4'b0000, 2'b00, 2'b00, W_NO_SNP, 0};
      vecs[11] = '{1, 4'd12, 64'h2040, 4'b0000, 2'b11, 2'b00, W_NO_SNP, 0};
      vecs[12] = '{1, 4'd13, 64'h2080, 4'b0011, 2'b01, 2'b00, W_BACK,   0};
      vecs[13] = '{1, 4'd14, 64'h20c0, 4'b0011, 2'b00, 2'b00, W_BACK,   0};
      vecs[14] = '{1, 4'd15, 64'h2100, 4'b0011, 2'b11, 2'b00, W_NO_SNP, 1};
      vecs[15] = '{1, 4'd0,  64'h2140, 4'b0000, 2'b01, 2'b00, W_NO_SNP, 1};
      vecs[16] = '{1, 4'd3,  64'h2180, 4'b0011, 2'b10, 2'b01, W_NO_SNP, 1};

      // Reset with both channels asserting valid: no ready, cleared outputs.
      idleInputs();
      reqReady = 1;
      rstN = 0;
      awValid = 1; arValid = 1;
      #1;
      check("rst_aw_ready", awReady, 0);
      check("rst_ar_ready", arReady, 0);
      tick();
      check("rst_aw_ready_post", awReady, 0);
      check("rst_ar_ready_post", arReady, 0);
      check("rst_req_valid", reqValid, 0);
      check("rst_err_cnt", errCnt, 0);
      check("rst_trs", reqTrs, 0);
      check("rst_write", reqWrite, 0);
      check("rst_unsup", reqUnsup, 0);
      check("rst_id", reqId, 0);
      check("rst_addr", reqAddr, 0);
      rstN = 1;
      idleInputs();
      tick();
      check("idle_req_valid", reqValid, 0);

      // Decode table, back to back with the sink always ready.
      for (int i = 0; i < 17; i++) begin
         idleInputs();
         if (vecs[i].isAw) begin
            awValid = 1; awId = vecs[i].id; awAddr = vecs[i].addr;
            awSnoop = vecs[i].snoop[2:0]; awDomain = vecs[i].domain; awBar = vecs[i].bar;
         end else begin
            arValid = 1; arId = vecs[i].id; arAddr = vecs[i].addr;
            arSnoop = vecs[i].snoop; arDomain = vecs[i].domain; arBar = vecs[i].bar;
         end
         #1;
         check($sformatf("vec%0d_aw_ready", i), awReady, vecs[i].isAw);
         check($sformatf("vec%0d_ar_ready", i), arReady, !vecs[i].isAw);
         tick();
         if (vecs[i].expUnsup) bumpErr();
         check($sformatf("vec%0d_valid", i), reqValid, 1);
         check($sformatf("vec%0d_trs", i), reqTrs, vecs[i].expTrs);
         check($sformatf("vec%0d_write", i), reqWrite, vecs[i].isAw);
         check($sformatf("vec%0d_id", i), reqId, vecs[i].id);
         check($sformatf("vec%0d_addr", i), reqAddr, vecs[i].addr);
         check($sformatf("vec%0d_unsup", i), reqUnsup, vecs[i].expUnsup);
         check($sformatf("vec%0d_err_cnt", i), errCnt, expErr);
      end
      idleInputs();
      tick();
      check("drain_valid", reqValid, 0);

      // Sustained contention: AR, AW, AR, AW, then the token is back at AR.
      awValid = 1; awId = 4'hA; awAddr = 64'h3000; awSnoop = 3'b000; awDomain = 2'b00;
      arValid = 1; arId = 4'hB; arAddr = 64'h4000; arSnoop = 4'b0000; arDomain = 2'b00;
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("cont%0d_ar_ready", k), arReady, (k % 2) == 0);
         check($sformatf("cont%0d_aw_ready", k), awReady, (k % 2) == 1);
         tick();
         check($sformatf("cont%0d_write", k), reqWrite, (k % 2) == 1);
         check($sformatf("cont%0d_id", k), reqId, (k % 2) == 1 ? 4'hA : 4'hB);
      end
      #1;
      check("cont_token_ar", arReady, 1);
      check("cont_token_aw", awReady, 0);
      idleInputs();
      tick();

      // Backpressure: entry full, sink stalled for 5 cycles, then released.
      reqReady = 0;
      arValid = 1; arId = 4'd5; arAddr = 64'h5000; arSnoop = 4'b0000; arDomain = 2'b00;
      #1;
      check("bp_first_ar_ready", arReady, 1);
      tick();
      idleInputs();
      awValid = 1; awId = 4'd6; awAddr = 64'h6000; awSnoop = 3'b011; awDomain = 2'b10;
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("bp%0d_aw_ready", k), awReady, 0);
         check($sformatf("bp%0d_ar_ready", k), arReady, 0);
         tick();
         check($sformatf("bp%0d_valid", k), reqValid, 1);
         check($sformatf("bp%0d_id", k), reqId, 4'd5);
         check($sformatf("bp%0d_addr", k), reqAddr, 64'h5000);
         check($sformatf("bp%0d_trs", k), reqTrs, R_NO_SNP);
         check($sformatf("bp%0d_write", k), reqWrite, 0);
      end
      reqReady = 1;
      #1;
      check("bp_release_aw_ready", awReady, 1);
      tick();
      check("bp_new_valid", reqValid, 1);
      check("bp_new_write", reqWrite, 1);
      check("bp_new_id", reqId, 4'd6);
      check("bp_new_addr", reqAddr, 64'h6000);
      check("bp_new_trs", reqTrs, W_BACK);
      idleInputs();
      tick();
      check("bp_drain_valid", reqValid, 0);

      // Error counter saturation with 300 unsupported writes.
      awValid = 1; awId = 4'd1; awAddr = 64'h7000; awSnoop = 3'b011; awDomain = 2'b11;
      for (int k = 0; k < 300; k++) begin
         tick();
         bumpErr();
      end
      check("sat_unsup", reqUnsup, 1);
      check("sat_trs", reqTrs, W_NO_SNP);
      check("sat_err_cnt", errCnt, expErr);
      check("sat_err_cnt_255", errCnt, 8'd255);
      idleInputs();
      tick();

      // Reset while the entry is held: entry discarded, counter cleared.
      reqReady = 0;
      arValid = 1; arId = 4'd9; arAddr = 64'h8000; arSnoop = 4'b0001; arDomain = 2'b01;
      tick();
      check("mid_loaded_valid", reqValid, 1);
      idleInputs();
      rstN = 0;
      tick();
      expErr = 0;
      check("mid_rst_valid", reqValid, 0);
      check("mid_rst_err_cnt", errCnt, expErr);
      check("mid_rst_id", reqId, 0);
      check("mid_rst_addr", reqAddr, 0);
      check("mid_rst_trs", reqTrs, 0);
      rstN = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("mid_post%0d_valid", k), reqValid, 0);
      end
      reqReady = 1;
      tick();
      check("mid_post_ready_valid", reqValid, 0);
      check("mid_post_err_cnt", errCnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ace_trs_decoder.md
ACE_TRS_DECODER -- requirements
Module: ace_trs_decoder

Interface
REQ-001 SHALL have parameter IdWidth, default 4: width of the AW/AR/request ID fields.
REQ-002 SHALL have parameter AddrWidth, default 64: width of the address fields.
REQ-003 SHALL have ports: clk_i  in  1  sole clock; all logic on the rising edge.
REQ-004 SHALL have ports: rst_ni  in  1  reset, synchronous, active-low.
REQ-005 SHALL have AW ports: aw_valid_i in 1; aw_ready_o out 1; aw_id_i in IdWidth; aw_addr_i in AddrWidth; aw_snoop_i in 3 (awsnoop_t); aw_domain_i in 2 (domain_t); aw_bar_i in 2 (bar_t).
REQ-006 SHALL have AR ports: ar_valid_i in 1; ar_ready_o out 1; ar_id_i in IdWidth; ar_addr_i in AddrWidth; ar_snoop_i in 4 (arsnoop_t); ar_domain_i in 2; ar_bar_i in 2.
REQ-007 SHALL have request ports: req_valid_o out 1; req_ready_i in 1; req_trs_o out 3 (ace_trs_t); req_write_o out 1 (1 = from AW); req_id_o out IdWidth; req_addr_o out AddrWidth; req_unsupported_o out 1.
REQ-008 SHALL have port err_cnt_o  out  8  saturating count of unsupported requests.

Function
REQ-009 SHALL hold a single output register (one entry); the stage can accept when the entry is empty, or when it is full and req_ready_i=1 in the same cycle.
REQ-010 SHALL present req_* one cycle after the input handshake; req_* SHALL remain stable while req_valid_o=1 and req_ready_i=0.
REQ-011 SHALL sustain one request per cycle when req_ready_i is held at 1.
REQ-012 SHALL assert at most one of aw_ready_o/ar_ready_o per cycle; ready SHALL be 0 for a channel whose valid is 0.
REQ-013 With exactly one channel valid and the stage able to accept, that channel SHALL receive ready.
REQ-014 With both channels valid, a 1-bit priority token SHALL select the winner; token reset value = AR; the token SHALL flip to the other channel only after a contended grant (both valid), giving strict alternation under sustained contention.
REQ-015 AR decode: bar[0]=1 -> unsupported; domain 00 or 11 and snoop 0000 -> R_NO_SNP; domain 01/10: snoop 0000 -> R_ONCE, 0001 -> R_SHARED, 1001 -> C_INVALID, 1011 -> C_UNIQUE; all other combinations -> unsupported.
REQ-016 AW decode: bar[0]=1 -> unsupported; snoop 000 with domain 00/11 -> W_NO_SNP; snoop 011 with domain 00/01/10 -> W_BACK; all other combinations -> unsupported.
REQ-017 An unsupported request SHALL still be forwarded, with req_unsupported_o=1 and req_trs_o forced to R_NO_SNP (AR) or W_NO_SNP (AW).
REQ-018 err_cnt_o SHALL increment by 1 on each accepted unsupported input handshake and saturate at 255 (no wrap).
REQ-019 req_id_o, req_addr_o SHALL be the captured values of the granted channel, unmodified; req_write_o = 1 for AW, 0 for AR.
REQ-020 Decode SHALL be combinational on the inputs and registered with the entry; no additional latency.

Reset
REQ-021 While rst_ni=0 at a clock edge: req_valid_o=0, err_cnt_o=0, token=AR, req_trs_o/req_write_o/req_unsupported_o=0, req_id_o/req_addr_o=0.
REQ-022 aw_ready_o and ar_ready_o SHALL be 0 during any cycle in which rst_ni=0.
REQ-023 Reset mid-operation SHALL discard any held entry; no request SHALL be emitted for it after reset deasserts.

Verification
REQ-024 AR only, snoop=0001, domain=01, id=3, addr=0x1000, req_ready_i=1 -> next cycle req_valid_o=1, req_trs_o=R_SHARED, req_write_o=0, req_id_o=3, req_addr_o=0x1000.
REQ-025 AW and AR both valid for 4 cycles, req_ready_i=1 -> grants AR, AW, AR, AW in order; token ends at AR.
REQ-026 AW snoop=011 domain=11 -> req_unsupported_o=1, req_trs_o=W_NO_SNP, err_cnt_o 0->1; 300 such requests -> err_cnt_o=255.
REQ-027 Entry full, req_ready_i=0 for 5 cycles -> aw_ready_o=ar_ready_o=0, req_* stable; req_ready_i=1 -> pending input accepted the same cycle, new entry next cycle.
REQ-028 ar_bar_i=01 with otherwise valid R_ONCE encoding -> forwarded as unsupported, R_NO_SNP.
REQ-029 rst_ni=0 for one cycle while entry full -> req_valid_o=0 next cycle, err_cnt_o=0, no stale request afterwards.
